execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Execute (EX) stage of the 5-stage RV32I core, between decode and memory.
//  - Computes the ALU result, the branch decision and the branch target.
//  - Registers them, together with the pass-through control fields, into the
//    EX/MEM pipeline register.
//  - Also forwards op1, csr_cmd and imm_i to the CSR stage.
// PARAMETERS
//  none (all widths fixed: XLEN=32)
// PORTS
//  clk               in   1   clock; all state updates on rising edge
//  rst               in   1   reset, synchronous, active-high
//  stall_flg         in   1   memory-stage stall; 1 = hold every output register
//  input_reg_pc      in   32  PC of the instruction in EX
//  input_exe_fun     in   5   ALU/branch function code (core_pkg EXE_*)
//  input_op1_data    in   32  operand 1
//  input_op2_data    in   32  operand 2
//  input_rs2_data    in   32  rs2 value (store data)
//  input_mem_wen     in   5   memory command, passed through
//  input_wb_sel      in   4   write-back select, passed through
//  input_csr_cmd     in   3   CSR command, passed through
//  input_imm_i_sext  in   32  sign-extended I immediate
//  input_imm_b_sext  in   32  sign-extended B immediate
//  alu_out           out  32  registered ALU result
//  br_flg            out  1   registered branch-taken flag
//  br_target         out  32  registered input_reg_pc + input_imm_b_sext
//  output_reg_pc     out  32  registered input_reg_pc
//  output_mem_wen    out  5   registered input_mem_wen
//  output_wb_sel     out  4   registered input_wb_sel
//  output_rs2_data   out  32  registered input_rs2_data
//  output_op1_data   out  32  registered input_op1_data (to CSR stage)
//  output_csr_cmd    out  3   registered input_csr_cmd
//  output_imm_i      out  32  registered input_imm_i_sext
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge sets every output to 0.
//    Reset has priority over stall_flg.
//  - Normal operation: rst=0, stall_flg=0. Every output loads its next value
//    each edge. Latency is 1 cycle; no handshake.
//  - Stall: stall_flg=1 (and rst=0) holds all outputs unchanged.
//    Inputs present during a stall are dropped; decode holds them upstream.
//  - exe_fun codes (ALU result written to alu_out):
//      0  X      result 0
//      1  ADD    op1+op2 (mod 2^32)
//      2  SUB    op1-op2
//      3  AND
//      4  OR
//      5  XOR
//      6  SLL    op1 << op2[4:0]
//      7  SRL    logical right shift by op2[4:0]
//      8  SRA    arithmetic right shift by op2[4:0]
//      9  SLT    signed less-than; result 1 or 0
//      10 SLTU   unsigned less-than; result 1 or 0
//      17 JALR   (op1+op2) & ~32'h1
//      18 COPY1  op1
//  - Branch codes 11..16 are BEQ, BNE, BLT, BGE, BLTU, BGEU.
//    They compare op1 with op2; signed for BLT/BGE, unsigned for BLTU/BGEU.
//    br_flg is 1 when the compare is true; alu_out is 0 for these codes.
//  - br_flg is 0 for every non-branch code.
//    br_target is computed for every instruction regardless of code.
//  - Undefined codes give alu_out=0 and br_flg=0.
//  - No flush input: a taken branch is redirected elsewhere in the core.
//    This stage does not squash its own next instruction.
// CONFIGURATION
//  - EXE_MUL_EN defined adds the RV32M multiply codes, low/high 32 bits of the
//    64-bit product:
//      19 MUL     low 32 bits
//      20 MULH    high 32, signed x signed
//      21 MULHSU  high 32, signed x unsigned
//      22 MULHU   high 32, unsigned x unsigned
//  - EXE_MUL_EN undefined: codes 19..22 are undefined (alu_out=0).
// STRUCTURE
//  - core_pkg holds the EXE_* function-code constants (5-bit), the
//    MEN_*/WB_*/CSR_* widths, and XLEN.
//  - One combinational sub-module, exe_alu, takes fun, op1 and op2 and
//    returns result and br_flg.
//  - execute_stage keeps only the pipeline registers, plus the adder for
//    br_target.
// TESTING
//  1. rst=1, then release: all outputs 0.
//     Next edge with ADD, op1=5, op2=7, pc=0x100: alu_out=12, output_reg_pc=0x100.
//  2. SUB op1=0, op2=1 -> alu_out=0xFFFFFFFF.
//     SRA op1=0x80000000, op2=0x21 (shift 1) -> alu_out=0xC0000000.
//  3. SLT op1=0xFFFFFFFF, op2=1 -> alu_out=1.
//     SLTU with the same operands -> alu_out=0.
//  4. BLT op1=-3, op2=2, pc=0x40, imm_b=-8 -> br_flg=1, br_target=0x38.
//     BGEU with the same operands -> br_flg=1.
//     BEQ op1=1, op2=2 -> br_flg=0.
//  5. Load ADD 1+1, then raise stall_flg for 3 cycles with new inputs (XOR 3,5):
//     outputs stay alu_out=2 during the stall, then 6 one edge after release.
//     rst=1 during a stall forces all outputs to 0.
//  6. JALR op1=0x1001, op2=2 -> alu_out=0x1002.
//     Pass-through fields (mem_wen=3, wb_sel=2, csr_cmd=5, imm_i=0x7FF,
//     rs2=0xDEAD) appear one cycle later.
//     With EXE_MUL_EN: MULHU 0xFFFFFFFF x 2 -> alu_out=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: XLEN, pipeline field widths and EX function codes.
// EXE_MUL/EXE_MULH/EXE_MULHSU/EXE_MULHU are only implemented when EXE_MUL_EN is defined.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned EXE_FUN_LEN = 5;
    localparam int unsigned MEN_LEN    = 5;
    localparam int unsigned WB_SEL_LEN = 4;
    localparam int unsigned CSR_LEN    = 3;

    typedef enum logic [EXE_FUN_LEN-1:0] {
        EXE_X      = 5'd0,
        EXE_ADD    = 5'd1,
        EXE_SUB    = 5'd2,
        EXE_AND    = 5'd3,
        EXE_OR     = 5'd4,
        EXE_XOR    = 5'd5,
        EXE_SLL    = 5'd6,
        EXE_SRL    = 5'd7,
        EXE_SRA    = 5'd8,
        EXE_SLT    = 5'd9,
        EXE_SLTU   = 5'd10,
        EXE_BEQ    = 5'd11,
        EXE_BNE    = 5'd12,
        EXE_BLT    = 5'd13,
        EXE_BGE    = 5'd14,
        EXE_BLTU   = 5'd15,
        EXE_BGEU   = 5'd16,
        EXE_JALR   = 5'd17,
        EXE_COPY1  = 5'd18,
        EXE_MUL    = 5'd19,
        EXE_MULH   = 5'd20,
        EXE_MULHSU = 5'd21,
        EXE_MULHU  = 5'd22
    } exe_fun_e;

    // Upper half of a 64-bit product; operands are extended per their signedness.
    function automatic logic [XLEN-1:0] mul_high(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic a_signed,
                                                 input logic b_signed);
        logic [2*XLEN-1:0] ax;
        logic [2*XLEN-1:0] bx;
        logic [2*XLEN-1:0] prod;
        ax   = {{XLEN{a_signed & a[XLEN-1]}}, a};
        bx   = {{XLEN{b_signed & b[XLEN-1]}}, b};
        prod = ax * bx;
        return prod[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU and branch comparator of the EX stage.
// Defining EXE_MUL_EN adds the RV32M MUL/MULH/MULHSU/MULHU codes.
module exe_alu
    import core_pkg::*;
(
    input  logic [EXE_FUN_LEN-1:0] fun,
    input  logic [XLEN-1:0]        op1,
    input  logic [XLEN-1:0]        op2,
    output logic [XLEN-1:0]        result,
    output logic                   br_flg
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] sum;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            eq;

    always_comb begin
        shamt       = op2[4:0];
        sum         = op1 + op2;
        lt_signed   = $signed(op1) < $signed(op2);
        lt_unsigned = op1 < op2;
        eq          = op1 == op2;
    end

    always_comb begin
        result = '0;
        case (fun)
            EXE_ADD:   result = sum;
            EXE_SUB:   result = op1 - op2;
            EXE_AND:   result = op1 & op2;
            EXE_OR:    result = op1 | op2;
            EXE_XOR:   result = op1 ^ op2;
            EXE_SLL:   result = op1 << shamt;
            EXE_SRL:   result = op1 >> shamt;
            EXE_SRA:   result = $signed(op1) >>> shamt;
            EXE_SLT:   result = {{(XLEN-1){1'b0}}, lt_signed};
            EXE_SLTU:  result = {{(XLEN-1){1'b0}}, lt_unsigned};
            EXE_JALR:  result = {sum[XLEN-1:1], 1'b0};
            EXE_COPY1: result = op1;
`ifdef EXE_MUL_EN
            EXE_MUL:    result = op1 * op2;
            EXE_MULH:   result = mul_high(op1, op2, 1'b1, 1'b1);
            EXE_MULHSU: result = mul_high(op1, op2, 1'b1, 1'b0);
            EXE_MULHU:  result = mul_high(op1, op2, 1'b0, 1'b0);
`endif
            default:   result = '0;
        endcase
    end

    always_comb begin
        br_flg = 1'b0;
        case (fun)
            EXE_BEQ:  br_flg = eq;
            EXE_BNE:  br_flg = ~eq;
            EXE_BLT:  br_flg = lt_signed;
            EXE_BGE:  br_flg = ~lt_signed;
            EXE_BLTU: br_flg = lt_unsigned;
            EXE_BGEU: br_flg = ~lt_unsigned;
            default:  br_flg = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the RV32I core: ALU/branch evaluation plus the EX/MEM pipeline register.
// The multiply extension inside exe_alu is enabled by defining EXE_MUL_EN.
module execute_stage
    import core_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_flg,
    input  logic [XLEN-1:0]        input_reg_pc,
    input  logic [EXE_FUN_LEN-1:0] input_exe_fun,
    input  logic [XLEN-1:0]        input_op1_data,
    input  logic [XLEN-1:0]        input_op2_data,
    input  logic [XLEN-1:0]        input_rs2_data,
    input  logic [MEN_LEN-1:0]     input_mem_wen,
    input  logic [WB_SEL_LEN-1:0]  input_wb_sel,
    input  logic [CSR_LEN-1:0]     input_csr_cmd,
    input  logic [XLEN-1:0]        input_imm_i_sext,
    input  logic [XLEN-1:0]        input_imm_b_sext,
    output logic [XLEN-1:0]        alu_out,
    output logic                   br_flg,
    output logic [XLEN-1:0]        br_target,
    output logic [XLEN-1:0]        output_reg_pc,
    output logic [MEN_LEN-1:0]     output_mem_wen,
    output logic [WB_SEL_LEN-1:0]  output_wb_sel,
    output logic [XLEN-1:0]        output_rs2_data,
    output logic [XLEN-1:0]        output_op1_data,
    output logic [CSR_LEN-1:0]     output_csr_cmd,
    output logic [XLEN-1:0]        output_imm_i
);

    logic [XLEN-1:0] alu_result;
    logic            alu_br_flg;
    logic [XLEN-1:0] target;

    exe_alu u_alu (
        .fun    (input_exe_fun),
        .op1    (input_op1_data),
        .op2    (input_op2_data),
        .result (alu_result),
        .br_flg (alu_br_flg)
    );

    // Target is produced for every instruction; only branches consume it downstream.
    always_comb begin
        target = input_reg_pc + input_imm_b_sext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out         <= '0;
            br_flg          <= 1'b0;
            br_target       <= '0;
            output_reg_pc   <= '0;
            output_mem_wen  <= '0;
            output_wb_sel   <= '0;
            output_rs2_data <= '0;
            output_op1_data <= '0;
            output_csr_cmd  <= '0;
            output_imm_i    <= '0;
        end else if (!stall_flg) begin
            alu_out         <= alu_result;
            br_flg          <= alu_br_flg;
            br_target       <= target;
            output_reg_pc   <= input_reg_pc;
            output_mem_wen  <= input_mem_wen;
            output_wb_sel   <= input_wb_sel;
            output_rs2_data <= input_rs2_data;
            output_op1_data <= input_op1_data;
            output_csr_cmd  <= input_csr_cmd;
            output_imm_i    <= input_imm_i_sext;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic vs a reference model.
// Define EXE_MUL_EN consistently with the RTL build to exercise the multiply codes.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_flg;
    logic [31:0] input_reg_pc;
    logic [4:0]  input_exe_fun;
    logic [31:0] input_op1_data;
    logic [31:0] input_op2_data;
    logic [31:0] input_rs2_data;
    logic [4:0]  input_mem_wen;
    logic [3:0]  input_wb_sel;
    logic [2:0]  input_csr_cmd;
    logic [31:0] input_imm_i_sext;
    logic [31:0] input_imm_b_sext;
    logic [31:0] alu_out;
    logic        br_flg;
    logic [31:0] br_target;
    logic [31:0] output_reg_pc;
    logic [4:0]  output_mem_wen;
    logic [3:0]  output_wb_sel;
    logic [31:0] output_rs2_data;
    logic [31:0] output_op1_data;
    logic [2:0]  output_csr_cmd;
    logic [31:0] output_imm_i;

    int checks = 0;
    int errors = 0;

    // Reference copy of the EX/MEM register contents
    logic [31:0] m_alu, m_tgt, m_pc, m_rs2, m_op1, m_imm;
    logic        m_br;
    logic [4:0]  m_wen;
    logic [3:0]  m_wb;
    logic [2:0]  m_csr;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_flg        (stall_flg),
        .input_reg_pc     (input_reg_pc),
        .input_exe_fun    (input_exe_fun),
        .input_op1_data   (input_op1_data),
        .input_op2_data   (input_op2_data),
        .input_rs2_data   (input_rs2_data),
        .input_mem_wen    (input_mem_wen),
        .input_wb_sel     (input_wb_sel),
        .input_csr_cmd    (input_csr_cmd),
        .input_imm_i_sext (input_imm_i_sext),
        .input_imm_b_sext (input_imm_b_sext),
        .alu_out          (alu_out),
        .br_flg           (br_flg),
        .br_target        (br_target),
        .output_reg_pc    (output_reg_pc),
        .output_mem_wen   (output_mem_wen),
        .output_wb_sel    (output_wb_sel),
        .output_rs2_data  (output_rs2_data),
        .output_op1_data  (output_op1_data),
        .output_csr_cmd   (output_csr_cmd),
        .output_imm_i     (output_imm_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction semantics from plain integer arithmetic on 64-bit values.
    function automatic void ref_exec(input int unsigned f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic t);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        int unsigned     sh;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a) & 64'hFFFF_FFFF;
        ub = longint'(b) & 64'hFFFF_FFFF;
        sh = b % 32;
        r  = 32'd0;
        t  = 1'b0;
        p  = 64'd0;
        case (f)
            1:  r = 32'(ua + ub);
            2:  r = 32'(ua - ub);
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = 32'(ua * (64'd1 << sh));
            7:  r = 32'(ua / (64'd1 << sh));
            8:  r = 32'(sa >>> sh);
            9:  r = (sa < sb) ? 32'd1 : 32'd0;
            10: r = (ua < ub) ? 32'd1 : 32'd0;
            11: t = (ua == ub);
            12: t = (ua != ub);
            13: t = (sa < sb);
            14: t = (sa >= sb);
            15: t = (ua < ub);
            16: t = (ua >= ub);
            17: begin r = 32'(ua + ub); r[0] = 1'b0; end
            18: r = a;
`ifdef EXE_MUL_EN
            19: begin p = ua * ub; r = p[31:0]; end
            20: begin p = 64'(sa * sb); r = p[63:32]; end
            21: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
            22: begin p = ua * ub; r = p[63:32]; end
`endif
            default: r = 32'd0;
        endcase
    endfunction

    task automatic compare_all();
        check("alu_out",   alu_out,                  m_alu);
        check("br_flg",    {31'd0, br_flg},          {31'd0, m_br});
        check("br_target", br_target,                m_tgt);
        check("reg_pc",    output_reg_pc,            m_pc);
        check("mem_wen",   {27'd0, output_mem_wen},  {27'd0, m_wen});
        check("wb_sel",    {28'd0, output_wb_sel},   {28'd0, m_wb});
        check("rs2_data",  output_rs2_data,          m_rs2);
        check("op1_data",  output_op1_data,          m_op1);
        check("csr_cmd",   {29'd0, output_csr_cmd},  {29'd0, m_csr});
        check("imm_i",     output_imm_i,             m_imm);
    endtask

    // One clock: update the model from the current inputs, then sample the DUT 1 time unit later.
    task automatic step();
        logic [31:0] r;
        logic        t;
        @(posedge clk);
        if (rst) begin
            {m_alu, m_tgt, m_pc, m_rs2, m_op1, m_imm} = '0;
            m_br = 1'b0; m_wen = '0; m_wb = '0; m_csr = '0;
        end else if (!stall_flg) begin
            ref_exec(int'(input_exe_fun), input_op1_data, input_op2_data, r, t);
            m_alu = r;
            m_br  = t;
            m_tgt = input_reg_pc + input_imm_b_sext;
            m_pc  = input_reg_pc;
            m_wen = input_mem_wen;
            m_wb  = input_wb_sel;
            m_rs2 = input_rs2_data;
            m_op1 = input_op1_data;
            m_csr = input_csr_cmd;
            m_imm = input_imm_i_sext;
        end
        #1;
        compare_all();
    endtask

    task automatic set_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] immb);
        input_exe_fun    = f;
        input_op1_data   = a;
        input_op2_data   = b;
        input_reg_pc     = pc;
        input_imm_b_sext = immb;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_alu = '0; m_tgt = '0; m_pc = '0; m_rs2 = '0; m_op1 = '0; m_imm = '0;
        m_br = 1'b0; m_wen = '0; m_wb = '0; m_csr = '0;
        rst = 1'b1;
        stall_flg = 1'b0;
        input_rs2_data = 32'h0; input_mem_wen = '0; input_wb_sel = '0;
        input_csr_cmd = '0; input_imm_i_sext = 32'h0;
        set_op(5'd1, 32'd9, 32'd9, 32'h44, 32'h4);
        step();
        step();
        check("rst_alu_zero", alu_out, 32'd0);
        check("rst_pc_zero",  output_reg_pc, 32'd0);

        rst = 1'b0;
        set_op(5'd1, 32'd5, 32'd7, 32'h100, 32'd0);
        step();
        check("add_5_7", alu_out, 32'd12);
        check("add_pc",  output_reg_pc, 32'h100);

        set_op(5'd2, 32'd0, 32'd1, 32'h104, 32'd0);
        step();
        check("sub_0_1", alu_out, 32'hFFFF_FFFF);
        set_op(5'd8, 32'h8000_0000, 32'h21, 32'h108, 32'd0);
        step();
        check("sra_shift1", alu_out, 32'hC000_0000);
        set_op(5'd9, 32'hFFFF_FFFF, 32'd1, 32'h10C, 32'd0);
        step();
        check("slt_neg", alu_out, 32'd1);
        set_op(5'd10, 32'hFFFF_FFFF, 32'd1, 32'h110, 32'd0);
        step();
        check("sltu_big", alu_out, 32'd0);

        set_op(5'd13, 32'hFFFF_FFFD, 32'd2, 32'h40, 32'hFFFF_FFF8);
        step();
        check("blt_taken",  {31'd0, br_flg}, 32'd1);
        check("blt_target", br_target, 32'h38);
        check("blt_alu0",   alu_out, 32'd0);
        set_op(5'd16, 32'hFFFF_FFFD, 32'd2, 32'h40, 32'hFFFF_FFF8);
        step();
        check("bgeu_taken", {31'd0, br_flg}, 32'd1);
        set_op(5'd11, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF8);
        step();
        check("beq_not", {31'd0, br_flg}, 32'd0);

        set_op(5'd1, 32'd1, 32'd1, 32'h200, 32'd0);
        step();
        check("stall_pre", alu_out, 32'd2);
        stall_flg = 1'b1;
        set_op(5'd5, 32'd3, 32'd5, 32'h204, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", alu_out, 32'd2);
        end
        stall_flg = 1'b0;
        step();
        check("stall_release", alu_out, 32'd6);
        stall_flg = 1'b1;
        rst = 1'b1;
        step();
        check("rst_in_stall", alu_out, 32'd0);
        check("rst_in_stall_pc", output_reg_pc, 32'd0);
        rst = 1'b0;
        stall_flg = 1'b0;

        set_op(5'd17, 32'h1001, 32'd2, 32'h300, 32'd0);
        input_mem_wen = 5'd3; input_wb_sel = 4'd2; input_csr_cmd = 3'd5;
        input_imm_i_sext = 32'h7FF; input_rs2_data = 32'hDEAD;
        step();
        check("jalr", alu_out, 32'h1002);
        check("pt_mem_wen", {27'd0, output_mem_wen}, 32'd3);
        check("pt_wb_sel",  {28'd0, output_wb_sel}, 32'd2);
        check("pt_csr_cmd", {29'd0, output_csr_cmd}, 32'd5);
        check("pt_imm_i",   output_imm_i, 32'h7FF);
        check("pt_rs2",     output_rs2_data, 32'hDEAD);
        check("pt_op1",     output_op1_data, 32'h1001);

        set_op(5'd22, 32'hFFFF_FFFF, 32'd2, 32'h304, 32'd0);
        step();
`ifdef EXE_MUL_EN
        check("mulhu", alu_out, 32'd1);
`else
        check("mulhu_undef", alu_out, 32'd0);
`endif
        set_op(5'd23, 32'd4, 32'd4, 32'h308, 32'd0);
        step();
        check("undef_code", alu_out, 32'd0);

        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 49) == 0);
            stall_flg        = ($urandom_range(0, 4) == 0);
            input_exe_fun    = 5'($urandom_range(0, 31));
            input_op1_data   = pick_operand();
            input_op2_data   = ($urandom_range(0, 3) == 0) ? input_op1_data : pick_operand();
            input_reg_pc     = $urandom & 32'hFFFF_FFFC;
            input_imm_b_sext = pick_operand();
            input_rs2_data   = $urandom;
            input_mem_wen    = 5'($urandom);
            input_wb_sel     = 4'($urandom);
            input_csr_cmd    = 3'($urandom);
            input_imm_i_sext = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
